lsu_mem_if: RTL and testbench

Load/store interface stage sitting directly upstream of the data memory. It accepts one load or store request at a time from the pipeline MEM stage and word-aligns the address. Sub-word stores are performed as read-modify-write (merged full word, single write enable). Load data is extracted and sign/zero-extended before being returned to the pipeline. Misaligned, out-of-range and illegal-funct3 accesses are trapped without touching memory.

---
 rtl/lsu_mem_if.sv | 193 +++++++++++++++++++
 tb/tb_lsu_mem_if.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_if.sv
// Load/store stage in front of a single-port word-addressed data memory.
// Word-aligns requests, performs sub-word stores as read-modify-write and extends load data.
module lsu_mem_if #(
    parameter int MEM_WORDS = 4096,
    parameter int XLEN      = 32
) (
    input  logic            clk,
    input  logic            srst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_we,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            busy
);

    localparam logic [XLEN-1:0] MEM_WORDS_W = XLEN'(MEM_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic            we_reg;
    logic [2:0]      funct3_reg;
    logic [XLEN-1:0] addr_reg;
    logic [XLEN-1:0] wdata_reg;
    logic [XLEN-1:0] word_reg;
    logic [XLEN-1:0] resp_rdata_reg;
    logic            resp_err_reg;

    logic            f3_legal;
    logic            misaligned;
    logic            out_of_range;
    logic            req_illegal;
    logic [4:0]      shamt;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_ext;
    logic [XLEN-1:0] merged;
    logic [XLEN-1:0] word_index;

    // Legality of the incoming request, evaluated at the accept edge
    always_comb begin
        f3_legal = 1'b0;
        if (req_we) begin
            f3_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                       (req_funct3 == 3'b010);
        end else begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
                default:                                 f3_legal = 1'b0;
            endcase
        end

        misaligned = 1'b0;
        case (req_funct3[1:0])
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase

        out_of_range = (req_addr >> 2) >= MEM_WORDS_W;
        req_illegal  = !f3_legal || misaligned || out_of_range;
    end

    // Load extraction works on the live memory word during RD
    always_comb begin
        shamt   = {addr_reg[1:0], 3'b000};
        shifted = mem_rdata >> shamt;
        case (funct3_reg)
            3'b000:  load_ext = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {{(XLEN-8){1'b0}}, shifted[7:0]};
            3'b101:  load_ext = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    // Store merge: each byte lane takes new data only if the access covers it
    generate
        for (genvar gi = 0; gi < XLEN / 8; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic lane_sel;
            assign lane_sel = (funct3_reg[1:0] == 2'b10) ||
                              ((funct3_reg[1:0] == 2'b00) && (addr_reg[1:0] == LANE)) ||
                              ((funct3_reg[1:0] == 2'b01) && (addr_reg[1] == LANE[1]));
            assign merged[8*gi +: 8] =
                !lane_sel                    ? word_reg[8*gi +: 8]       :
                (funct3_reg[1:0] == 2'b10)   ? wdata_reg[8*gi +: 8]      :
                (funct3_reg[1:0] == 2'b01)   ? wdata_reg[8*(gi%2) +: 8]  :
                                               wdata_reg[7:0];
        end
    endgenerate

    assign word_index = {2'b00, addr_reg[XLEN-1:2]};

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b1;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_reg)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    if (req_illegal)
                        state_next = ST_RESP;
                    else if (req_we && (req_funct3[1:0] == 2'b10))
                        state_next = ST_WR;
                    else
                        state_next = ST_RD;
                end
            end
            ST_RD: begin
                mem_addr   = word_index;
                state_next = we_reg ? ST_WR : ST_RESP;
            end
            ST_WR: begin
                mem_addr   = word_index;
                // Gated by srst so a reset landing on the write edge cannot commit it
                mem_we     = !srst;
                mem_wdata  = merged;
                state_next = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            we_reg         <= 1'b0;
            funct3_reg     <= 3'b000;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            word_reg       <= '0;
            resp_rdata_reg <= '0;
            resp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_reg         <= req_we;
                        funct3_reg     <= req_funct3;
                        addr_reg       <= req_addr;
                        wdata_reg      <= req_wdata;
                        resp_err_reg   <= req_illegal;
                        resp_rdata_reg <= '0;
                    end
                end
                ST_RD: begin
                    word_reg <= mem_rdata;
                    if (!we_reg)
                        resp_rdata_reg <= load_ext;
                end
                default: ;
            endcase
        end
    end

    assign resp_rdata = resp_rdata_reg;
    assign resp_err   = resp_err_reg;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed testbench for lsu_mem_if with a behavioural data memory model.
module tb_lsu_mem_if;

    logic        clk;
    logic        srst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        busy;

    logic [31:0] tb_mem [0:4095];
    int          we_cnt;
    logic [31:0] last_waddr;
    int          errors;
    int          checks;

    lsu_mem_if #(.MEM_WORDS(4096), .XLEN(32)) dut (
        .clk        (clk),
        .srst       (srst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = (mem_addr < 32'd4096) ? tb_mem[mem_addr[11:0]] : 32'h0;

    always @(posedge clk) begin
        if (mem_we) begin
            if (mem_addr < 32'd4096)
                tb_mem[mem_addr[11:0]] <= mem_wdata;
            we_cnt     <= we_cnt + 1;
            last_waddr <= mem_addr;
        end
    end

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd,
                          output logic e);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = resp_rdata;
        e  = resp_err;
        $display("txn we=%0b f3=%03b addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d",
                 we, f3, addr, wd, rd, e, lat);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        srst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        srst = 1'b0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        checks++; if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp: got rdata=%h err=%b expected 0/0", resp_rdata, resp_err); end
    endtask

    task automatic test_sw_lw();
        int lat; logic [31:0] rd; logic e; int w0;
        w0 = we_cnt;
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, rd, e);
        checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d expected 2", lat); end
        checks++; if (we_cnt - w0 !== 1) begin errors++; $display("FAIL sw_we_pulses: got %0d expected 1", we_cnt - w0); end
        checks++; if (last_waddr !== 32'd4) begin errors++; $display("FAIL sw_mem_addr: got %h expected 4", last_waddr); end
        checks++; if (tb_mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_word: got %h expected deadbeef", tb_mem[4]); end
        checks++; if (rd !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL sw_resp: got rdata=%h err=%b expected 0/0", rd, e); end
        do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, e);
        checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency: got %0d expected 2", lat); end
        checks++; if (rd !== 32'hDEADBEEF || e !== 1'b0) begin errors++; $display("FAIL lw_data: got rdata=%h err=%b expected deadbeef/0", rd, e); end
    endtask

    task automatic test_sb();
        int lat; logic [31:0] rd; logic e;
        do_req(1'b1, 3'b000, 32'h11, 32'h123456A5, lat, rd, e);
        checks++; if (lat !== 3) begin errors++; $display("FAIL sb_latency: got %0d expected 3", lat); end
        checks++; if (tb_mem[4] !== 32'hDEADA5EF) begin errors++; $display("FAIL sb_word: got %h expected deada5ef", tb_mem[4]); end
        do_req(1'b0, 3'b000, 32'h11, 32'h0, lat, rd, e);
        checks++; if (rd !== 32'hFFFFFFA5 || lat !== 2) begin errors++; $display("FAIL lb_data: got %h lat=%0d expected ffffffa5 lat=2", rd, lat); end
        do_req(1'b0, 3'b100, 32'h11, 32'h0, lat, rd, e);
        checks++; if (rd !== 32'h000000A5) begin errors++; $display("FAIL lbu_data: got %h expected 000000a5", rd); end
        do_req(1'b0, 3'b100, 32'h13, 32'h0, lat, rd, e);
        checks++; if (rd !== 32'h000000DE) begin errors++; $display("FAIL lbu_lane3: got %h expected 000000de", rd); end
    endtask

    task automatic test_sh();
        int lat; logic [31:0] rd; logic e;
        do_req(1'b1, 3'b001, 32'h12, 32'hFFFF8001, lat, rd, e);
        checks++; if (lat !== 3) begin errors++; $display("FAIL sh_latency: got %0d expected 3", lat); end
        checks++; if (tb_mem[4] !== 32'h8001A5EF) begin errors++; $display("FAIL sh_word: got %h expected 8001a5ef", tb_mem[4]); end
        do_req(1'b0, 3'b001, 32'h12, 32'h0, lat, rd, e);
        checks++; if (rd !== 32'hFFFF8001) begin errors++; $display("FAIL lh_data: got %h expected ffff8001", rd); end
        do_req(1'b0, 3'b101, 32'h12, 32'h0, lat, rd, e);
        checks++; if (rd !== 32'h00008001) begin errors++; $display("FAIL lhu_data: got %h expected 00008001", rd); end
        do_req(1'b0, 3'b001, 32'h10, 32'h0, lat, rd, e);
        checks++; if (rd !== 32'hFFFFA5EF) begin errors++; $display("FAIL lh_low: got %h expected ffffa5ef", rd); end
    endtask

    task automatic test_faults();
        logic        f_we   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0]  f_f3   [4] = '{3'b010, 3'b001, 3'b011, 3'b010};
        logic [31:0] f_addr [4] = '{32'h13, 32'h11, 32'h10, 32'h4000};
        int lat; logic [31:0] rd; logic e; int w0; logic [31:0] snap;
        snap = tb_mem[4];
        for (int i = 0; i < 4; i++) begin
            w0 = we_cnt;
            do_req(f_we[i], f_f3[i], f_addr[i], 32'hCAFEF00D, lat, rd, e);
            checks++; if (e !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL fault%0d_resp: got err=%b rdata=%h expected 1/0", i, e, rd); end
            checks++; if (lat !== 1) begin errors++; $display("FAIL fault%0d_latency: got %0d expected 1", i, lat); end
            checks++; if (we_cnt !== w0) begin errors++; $display("FAIL fault%0d_we: got %0d pulses expected 0", i, we_cnt - w0); end
        end
        checks++; if (tb_mem[4] !== snap) begin errors++; $display("FAIL fault_mem: got %h expected %h", tb_mem[4], snap); end
        do_req(1'b1, 3'b010, 32'h3FFC, 32'h12345678, lat, rd, e);
        checks++; if (e !== 1'b0 || tb_mem[4095] !== 32'h12345678) begin errors++; $display("FAIL last_word: got err=%b word=%h expected 0/12345678", e, tb_mem[4095]); end
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        resp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        while (resp_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout: resp_valid=%b expected 1", resp_valid); end
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'h8001A5EF || resp_err !== 1'b0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b d=%h e=%b rdy=%b expected 1/8001a5ef/0/0", i, resp_valid, resp_rdata, resp_err, req_ready);
            end
            @(posedge clk);
            #1;
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        $display("txn backpressured lw addr=00000010 released");
        checks++; if (busy !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got busy=%b rdy=%b v=%b expected 0/1/0", busy, req_ready, resp_valid); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd; logic e; int w0; logic [31:0] snap;
        snap = tb_mem[4];
        w0   = we_cnt;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h10;
        req_wdata  = 32'h00000011;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy: got %b expected 1", busy); end
        srst = 1'b1;
        @(posedge clk);
        #1;
        srst = 1'b0;
        $display("txn sb addr=00000010 aborted by srst");
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_state: got rdy=%b v=%b busy=%b expected 1/0/0", req_ready, resp_valid, busy); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (tb_mem[4] !== snap || we_cnt !== w0) begin errors++; $display("FAIL rst_mid_mem: got %h pulses=%0d expected %h 0", tb_mem[4], we_cnt - w0, snap); end
        do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, e);
        checks++; if (rd !== 32'h8001A5EF || e !== 1'b0) begin errors++; $display("FAIL rst_mid_reload: got %h err=%b expected 8001a5ef/0", rd, e); end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        we_cnt     = 0;
        last_waddr = 32'h0;
        for (int i = 0; i < 4096; i++) tb_mem[i] = 32'h0;
        srst       = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b1;
        test_reset();
        test_sw_lw();
        test_sb();
        test_sh();
        test_faults();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
